regfile_wb_sched: RTL and testbench

Writeback scheduler for the 32×32 integer register file. It shares the file's single write port between the ALU result path and the multi-cycle load-return path. It keeps a per-register pending-load scoreboard for RAW/WAW hazard detection and forwards the winning source's funct3, so that LBU/LHU zero-extension happens at the register file. It sits between execute/LSU and the register file write port.

---
 rtl/regfile_wb_sched.sv | 187 ++++++++++++++++++
 tb/tb_regfile_wb_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
// Writeback scheduler for the 32x32 integer register file. The file has one
// write port. This block shares it between the ALU result path and the
// multi-cycle load-return path.
//
// It keeps a per-register pending-load scoreboard for RAW/WAW hazards. It also
// forwards funct3 with each write, so that LBU/LHU zero-extension is applied
// at the register file.
//
// Optional feature macro: WB_SKID_EN
//   Adds a one-entry skid buffer that catches an ALU result losing the write
//   port to a load return. Without it, the ALU is stalled whenever ld_valid
//   is high.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_addr/alu_data      ALU result handshake
//   ld_issue/ld_issue_ready/ld_issue_addr      load issue (reserves dest)
//   ld_valid/ld_addr/ld_data/ld_funct3         load return (never stalled)
//   rs1_addr, rs2_addr, hazard                 decode stall query
//   rf_we/rf_wr_addr/rf_wr_din/rf_funct3       registered write port
//   pend_cnt                                   outstanding load count
//   err                                        sticky bad-return flag
module regfile_wb_sched #(
    parameter int DEPTH   = 32,
    parameter int WIDTH   = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [$clog2(DEPTH)-1:0]     alu_addr,
    input  logic [WIDTH-1:0]             alu_data,
    input  logic                         ld_issue,
    output logic                         ld_issue_ready,
    input  logic [$clog2(DEPTH)-1:0]     ld_issue_addr,
    input  logic                         ld_valid,
    input  logic [$clog2(DEPTH)-1:0]     ld_addr,
    input  logic [WIDTH-1:0]             ld_data,
    input  logic [2:0]                   ld_funct3,
    input  logic [$clog2(DEPTH)-1:0]     rs1_addr,
    input  logic [$clog2(DEPTH)-1:0]     rs2_addr,
    output logic                         hazard,
    output logic                         rf_we,
    output logic [$clog2(DEPTH)-1:0]     rf_wr_addr,
    output logic [WIDTH-1:0]             rf_wr_din,
    output logic [2:0]                   rf_funct3,
    output logic [$clog2(MAX_OUT+1)-1:0] pend_cnt,
    output logic                         err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [2:0] F3_WORD = 3'b010;

    logic [DEPTH-1:0] pending_q, pending_d;
    logic [CW-1:0]    pend_cnt_q, pend_cnt_d;
    logic             err_q, err_d;
    logic             rf_we_q, rf_we_d;
    logic [AW-1:0]    rf_wr_addr_q, rf_wr_addr_d;
    logic [WIDTH-1:0] rf_wr_din_q, rf_wr_din_d;
    logic [2:0]       rf_funct3_q, rf_funct3_d;
`ifdef WB_SKID_EN
    logic             skid_full_q, skid_full_d;
    logic [AW-1:0]    skid_addr_q, skid_addr_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
`endif

    logic ld_ret_ok;
    logic ld_ret_bad;
    logic alu_wr;
    logic iss_set;
    logic haz_rs1;
    logic haz_rs2;

    always_comb begin
        // A return only owns the write port if its register is actually pending.
        ld_ret_ok  = ld_valid && pending_q[ld_addr];
        ld_ret_bad = ld_valid && !pending_q[ld_addr];
`ifdef WB_SKID_EN
        alu_ready      = !reset && !skid_full_q && !pending_q[alu_addr];
        // A parked ALU write to the same register must land before a new load
        // can reserve it.
        ld_issue_ready = !reset && !pending_q[ld_issue_addr]
                         && (pend_cnt_q < CW'(MAX_OUT))
                         && !(skid_full_q && skid_addr_q == ld_issue_addr);
`else
        alu_ready      = !reset && !ld_valid && !pending_q[alu_addr];
        ld_issue_ready = !reset && !pending_q[ld_issue_addr]
                         && (pend_cnt_q < CW'(MAX_OUT));
`endif
        alu_wr  = alu_valid && alu_ready && (alu_addr != '0);
        iss_set = ld_issue && ld_issue_ready && (ld_issue_addr != '0);

        pending_d = pending_q;
        if (ld_ret_ok) pending_d[ld_addr] = 1'b0;
        if (iss_set)   pending_d[ld_issue_addr] = 1'b1;
        pend_cnt_d = pend_cnt_q + CW'(iss_set) - CW'(ld_ret_ok);
        err_d      = err_q | ld_ret_bad;

        rf_we_d      = 1'b0;
        rf_wr_addr_d = rf_wr_addr_q;
        rf_wr_din_d  = rf_wr_din_q;
        rf_funct3_d  = rf_funct3_q;
`ifdef WB_SKID_EN
        skid_full_d = skid_full_q;
        skid_addr_d = skid_addr_q;
        skid_data_d = skid_data_q;
`endif
        if (ld_ret_ok) begin
            rf_we_d      = 1'b1;
            rf_wr_addr_d = ld_addr;
            rf_wr_din_d  = ld_data;
            rf_funct3_d  = ld_funct3;
`ifdef WB_SKID_EN
            // alu_wr implies the skid is empty, so capture never overwrites.
            if (alu_wr) begin
                skid_full_d = 1'b1;
                skid_addr_d = alu_addr;
                skid_data_d = alu_data;
            end
        end else if (skid_full_q) begin
            rf_we_d      = 1'b1;
            rf_wr_addr_d = skid_addr_q;
            rf_wr_din_d  = skid_data_q;
            rf_funct3_d  = F3_WORD;
            skid_full_d  = 1'b0;
`endif
        end else if (alu_wr) begin
            rf_we_d      = 1'b1;
            rf_wr_addr_d = alu_addr;
            rf_wr_din_d  = alu_data;
            rf_funct3_d  = F3_WORD;
        end
    end

    // A source is unsafe if its load is outstanding or its value is still on
    // its way to the register file.
    always_comb begin
        haz_rs1 = pending_q[rs1_addr] || (rf_we_q && rf_wr_addr_q == rs1_addr);
        haz_rs2 = pending_q[rs2_addr] || (rf_we_q && rf_wr_addr_q == rs2_addr);
`ifdef WB_SKID_EN
        if (skid_full_q && skid_addr_q == rs1_addr) haz_rs1 = 1'b1;
        if (skid_full_q && skid_addr_q == rs2_addr) haz_rs2 = 1'b1;
`endif
        hazard = ((rs1_addr != '0) && haz_rs1) || ((rs2_addr != '0) && haz_rs2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q    <= '0;
            pend_cnt_q   <= '0;
            err_q        <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_din_q  <= '0;
            rf_funct3_q  <= '0;
`ifdef WB_SKID_EN
            skid_full_q  <= 1'b0;
            skid_addr_q  <= '0;
            skid_data_q  <= '0;
`endif
        end else begin
            pending_q    <= pending_d;
            pend_cnt_q   <= pend_cnt_d;
            err_q        <= err_d;
            rf_we_q      <= rf_we_d;
            rf_wr_addr_q <= rf_wr_addr_d;
            rf_wr_din_q  <= rf_wr_din_d;
            rf_funct3_q  <= rf_funct3_d;
`ifdef WB_SKID_EN
            skid_full_q  <= skid_full_d;
            skid_addr_q  <= skid_addr_d;
            skid_data_q  <= skid_data_d;
`endif
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_wr_addr = rf_wr_addr_q;
    assign rf_wr_din  = rf_wr_din_q;
    assign rf_funct3  = rf_funct3_q;
    assign pend_cnt   = pend_cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid, alu_ready, ld_issue, ld_issue_ready, ld_valid;
    logic [4:0]  alu_addr, ld_issue_addr, ld_addr, rs1_addr, rs2_addr, rf_wr_addr;
    logic [31:0] alu_data, ld_data, rf_wr_din;
    logic [2:0]  ld_funct3, rf_funct3, pend_cnt;
    logic        hazard, rf_we, err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_wb_sched dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_ready(ld_issue_ready), .ld_issue_addr(ld_issue_addr),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_funct3(ld_funct3),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard(hazard),
        .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_din(rf_wr_din), .rf_funct3(rf_funct3),
        .pend_cnt(pend_cnt), .err(err)
    );

    typedef struct {
        int av, aa, ad, li, ia, lv, la, ld, lf, r1, r2;
        int ar, ir, hz, we, wa, wd, f3, cnt, er;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input int av, aa, ad, li, ia, lv, la, ld, lf, r1, r2,
                       input int ar, ir, hz, we, wa, wd, f3, cnt, er);
        vec_t v;
        v = '{av, aa, ad, li, ia, lv, la, ld, lf, r1, r2, ar, ir, hz, we, wa, wd, f3, cnt, er};
        tbl.push_back(v);
    endtask

    task automatic drive(input int av, aa, ad, li, ia, lv, la, ld, lf, r1, r2);
        alu_valid = 1'(av); alu_addr = 5'(aa); alu_data = 32'(ad);
        ld_issue = 1'(li); ld_issue_addr = 5'(ia);
        ld_valid = 1'(lv); ld_addr = 5'(la); ld_data = 32'(ld); ld_funct3 = 3'(lf);
        rs1_addr = 5'(r1); rs2_addr = 5'(r2);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // reference model state
    bit          pm[32];
    bit          m_err;
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic [2:0]  m_f3;

    function automatic int popcnt();
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(pm[r]);
        return c;
    endfunction

    function automatic bit model_haz(input logic [4:0] a);
        return (a != 0) && (pm[a] || (m_we && m_wa == a));
    endfunction

    initial begin
        int cands[$];
        int av, aa, ad, li, ia, lv, la, ld, lf, r1, r2;
        bit e_ar, e_ir, e_hz, ret_ok;
        string tag;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #2;
        chk("reset rf_wr_addr", 32'(rf_wr_addr), 0);
        chk("reset rf_wr_din", rf_wr_din, 0);
        chk("reset rf_funct3", 32'(rf_funct3), 0);
        #(-0);

`ifndef WB_SKID_EN
        //   av aa ad       li ia lv la ld       lf r1 r2 | ar ir hz we wa wd       f3 cnt er
        row(0, 0, 0,       0, 0, 0, 0, 0,       0, 0, 0,   1, 1, 0, 0, 0, 0,       0, 0, 0);
        row(1, 5, 'h1234,  0, 0, 0, 0, 0,       0, 0, 0,   1, 1, 0, 0, 0, 0,       0, 0, 0);
        row(0, 0, 0,       0, 0, 0, 0, 0,       0, 5, 0,   1, 1, 1, 1, 5, 'h1234,  2, 0, 0);
        row(0, 0, 0,       0, 0, 0, 0, 0,       0, 5, 0,   1, 1, 0, 0, 0, 0,       0, 0, 0);
        row(0, 0, 0,       1, 7, 0, 0, 0,       0, 0, 7,   1, 1, 0, 0, 0, 0,       0, 0, 0);
        row(0, 0, 0,       0, 0, 0, 0, 0,       0, 0, 7,   1, 1, 1, 0, 0, 0,       0, 1, 0);
        row(0, 0, 0,       0, 0, 1, 7, 'hFF80,  4, 0, 7,   0, 1, 1, 0, 0, 0,       0, 1, 0);
        row(0, 0, 0,       0, 0, 0, 0, 0,       0, 0, 7,   1, 1, 1, 1, 7, 'hFF80,  4, 0, 0);
        row(0, 0, 0,       0, 0, 0, 0, 0,       0, 0, 7,   1, 1, 0, 0, 0, 0,       0, 0, 0);
        row(1, 0, 5,       1, 0, 0, 0, 0,       0, 0, 0,   1, 1, 0, 0, 0, 0,       0, 0, 0);
        row(0, 0, 0,       0, 0, 0, 0, 0,       0, 0, 0,   1, 1, 0, 0, 0, 0,       0, 0, 0);
        row(0, 0, 0,       1, 7, 0, 0, 0,       0, 0, 0,   1, 1, 0, 0, 0, 0,       0, 0, 0);
        row(1, 9, 'h99,    0, 0, 1, 7, 'hAA,    2, 0, 0,   0, 1, 0, 0, 0, 0,       0, 1, 0);
        row(1, 9, 'h99,    0, 0, 0, 0, 0,       0, 0, 0,   1, 1, 0, 1, 7, 'hAA,    2, 0, 0);
        row(0, 0, 0,       0, 0, 0, 0, 0,       0, 9, 0,   1, 1, 1, 1, 9, 'h99,    2, 0, 0);
        row(0, 0, 0,       1, 3, 0, 0, 0,       0, 0, 0,   1, 1, 0, 0, 0, 0,       0, 0, 0);
        row(0, 0, 0,       1, 4, 0, 0, 0,       0, 0, 0,   1, 1, 0, 0, 0, 0,       0, 1, 0);
        row(0, 0, 0,       1, 5, 0, 0, 0,       0, 0, 0,   1, 1, 0, 0, 0, 0,       0, 2, 0);
        row(0, 0, 0,       1, 6, 0, 0, 0,       0, 0, 0,   1, 1, 0, 0, 0, 0,       0, 3, 0);
        row(0, 0, 0,       1, 8, 0, 0, 0,       0, 0, 0,   1, 0, 0, 0, 0, 0,       0, 4, 0);
        row(1, 3, 'h33,    1, 8, 0, 0, 0,       0, 3, 0,   0, 0, 1, 0, 0, 0,       0, 4, 0);
        row(1, 3, 'h33,    1, 8, 1, 3, 'h3,     0, 3, 0,   0, 0, 1, 0, 0, 0,       0, 4, 0);
        row(1, 3, 'h33,    1, 8, 0, 0, 0,       0, 3, 0,   1, 1, 1, 1, 3, 'h3,     0, 3, 0);
        row(0, 0, 0,       0, 0, 0, 0, 0,       0, 3, 0,   1, 0, 1, 1, 3, 'h33,    2, 4, 0);
        row(0, 0, 0,       0, 0, 1, 10, 1,      2, 8, 0,   0, 0, 1, 0, 0, 0,       0, 4, 0);
        row(0, 0, 0,       0, 0, 0, 0, 0,       0, 0, 0,   1, 0, 0, 0, 0, 0,       0, 4, 1);
        row(0, 0, 0,       0, 0, 1, 8, 'h88,    2, 0, 0,   0, 0, 0, 0, 0, 0,       0, 4, 1);
        row(0, 0, 0,       0, 0, 0, 0, 0,       0, 0, 0,   1, 1, 0, 1, 8, 'h88,    2, 3, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].li, tbl[i].ia, tbl[i].lv,
                  tbl[i].la, tbl[i].ld, tbl[i].lf, tbl[i].r1, tbl[i].r2);
            #2;
            tag = $sformatf("row%0d", i);
            chk({tag, " alu_ready"}, 32'(alu_ready), 32'(tbl[i].ar));
            chk({tag, " ld_issue_ready"}, 32'(ld_issue_ready), 32'(tbl[i].ir));
            chk({tag, " hazard"}, 32'(hazard), 32'(tbl[i].hz));
            chk({tag, " rf_we"}, 32'(rf_we), 32'(tbl[i].we));
            chk({tag, " pend_cnt"}, 32'(pend_cnt), 32'(tbl[i].cnt));
            chk({tag, " err"}, 32'(err), 32'(tbl[i].er));
            if (tbl[i].we != 0) begin
                chk({tag, " rf_wr_addr"}, 32'(rf_wr_addr), 32'(tbl[i].wa));
                chk({tag, " rf_wr_din"}, rf_wr_din, 32'(tbl[i].wd));
                chk({tag, " rf_funct3"}, 32'(rf_funct3), 32'(tbl[i].f3));
            end
            next_cycle();
        end
`else
        // skid build: a load return and an ALU result collide
        drive(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(1, 9, 'h99, 0, 0, 1, 7, 'hFF80, 4, 0, 0);
        #2;
        chk("skid alu_ready on collision", 32'(alu_ready), 1);
        next_cycle();
        drive(1, 11, 'h5, 0, 0, 0, 0, 0, 0, 9, 0);
        #2;
        chk("skid load first we", 32'(rf_we), 1);
        chk("skid load first addr", 32'(rf_wr_addr), 7);
        chk("skid load first funct3", 32'(rf_funct3), 4);
        chk("skid full alu_ready", 32'(alu_ready), 0);
        chk("skid hazard", 32'(hazard), 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("skid drain we", 32'(rf_we), 1);
        chk("skid drain addr", 32'(rf_wr_addr), 9);
        chk("skid drain din", rf_wr_din, 'h99);
        chk("skid drain funct3", 32'(rf_funct3), 2);
        next_cycle();
        drive(1, 12, 'h1, 1, 3, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(1, 13, 'h2, 1, 4, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
        next_cycle();
`endif

        // reset in the middle of operation with loads outstanding
        reset = 1'b1;
        drive(1, 1, 'h77, 1, 9, 0, 0, 0, 0, 4, 0);
        #2;
        chk("in-reset alu_ready", 32'(alu_ready), 0);
        chk("in-reset ld_issue_ready", 32'(ld_issue_ready), 0);
        next_cycle();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 5);
        #2;
        chk("post-reset pend_cnt", 32'(pend_cnt), 0);
        chk("post-reset rf_we", 32'(rf_we), 0);
        chk("post-reset err", 32'(err), 0);
        chk("post-reset hazard", 32'(hazard), 0);
        chk("post-reset rf_wr_addr", 32'(rf_wr_addr), 0);
        chk("post-reset rf_wr_din", rf_wr_din, 0);
        chk("post-reset ld_issue_ready", 32'(ld_issue_ready), 1);
        next_cycle();

`ifndef WB_SKID_EN
        // randomized traffic against the scoreboard model
        for (int r = 0; r < 32; r++) pm[r] = 1'b0;
        m_err = 1'b0;
        m_we  = 1'b0;
        m_wa  = '0;
        m_wd  = '0;
        m_f3  = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            av = int'($urandom_range(0, 1));
            aa = int'($urandom_range(0, 7));
            ad = int'($urandom);
            li = ($urandom_range(0, 2) == 0) ? 1 : 0;
            ia = int'($urandom_range(0, 7));
            lv = 0;
            la = int'($urandom_range(0, 7));
            ld = int'($urandom);
            lf = int'($urandom_range(0, 7));
            r1 = int'($urandom_range(0, 7));
            r2 = int'($urandom_range(0, 7));
            cands.delete();
            for (int r = 0; r < 32; r++) if (pm[r]) cands.push_back(r);
            if ($urandom_range(0, 1) == 0) begin
                if (cands.size() > 0 && $urandom_range(0, 15) != 0) begin
                    lv = 1;
                    la = cands[$urandom_range(0, cands.size() - 1)];
                end else if ($urandom_range(0, 7) == 0) begin
                    lv = 1;
                end
            end
            drive(av, aa, ad, li, ia, lv, la, ld, lf, r1, r2);
            #2;

            e_ar = (lv == 0) && !pm[aa];
            e_ir = !pm[ia] && (popcnt() < 4);
            e_hz = model_haz(5'(r1)) || model_haz(5'(r2));
            chk("rand alu_ready", 32'(alu_ready), 32'(e_ar));
            chk("rand ld_issue_ready", 32'(ld_issue_ready), 32'(e_ir));
            chk("rand hazard", 32'(hazard), 32'(e_hz));
            chk("rand rf_we", 32'(rf_we), 32'(m_we));
            chk("rand pend_cnt", 32'(pend_cnt), 32'(popcnt()));
            chk("rand err", 32'(err), 32'(m_err));
            if (m_we) begin
                chk("rand rf_wr_addr", 32'(rf_wr_addr), 32'(m_wa));
                chk("rand rf_wr_din", rf_wr_din, m_wd);
                chk("rand rf_funct3", 32'(rf_funct3), 32'(m_f3));
            end

            ret_ok = (lv != 0) && pm[la];
            if (lv != 0 && !pm[la]) m_err = 1'b1;
            if (ret_ok) begin
                m_we = 1'b1; m_wa = 5'(la); m_wd = 32'(ld); m_f3 = 3'(lf);
            end else if (av != 0 && e_ar && aa != 0) begin
                m_we = 1'b1; m_wa = 5'(aa); m_wd = 32'(ad); m_f3 = 3'b010;
            end else begin
                m_we = 1'b0;
            end
            if (ret_ok) pm[la] = 1'b0;
            if (li != 0 && e_ir && ia != 0) pm[ia] = 1'b1;
            next_cycle();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
